// File: rtl/_regfile32.sv
// Thirty-two entry register file with two combinational read ports, one write
// port and a per-register pending bit. Optional write-to-read forwarding: REGFILE_BYPASS_EN.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif

module _mux32 #(
  parameter int n = `BIT_WIDTH
) (
  input  logic [4:0]   sel_i,
  input  logic [n-1:0] in00_i,
  input  logic [n-1:0] in01_i,
  input  logic [n-1:0] in02_i,
  input  logic [n-1:0] in03_i,
  input  logic [n-1:0] in04_i,
  input  logic [n-1:0] in05_i,
  input  logic [n-1:0] in06_i,
  input  logic [n-1:0] in07_i,
  input  logic [n-1:0] in08_i,
  input  logic [n-1:0] in09_i,
  input  logic [n-1:0] in10_i,
  input  logic [n-1:0] in11_i,
  input  logic [n-1:0] in12_i,
  input  logic [n-1:0] in13_i,
  input  logic [n-1:0] in14_i,
  input  logic [n-1:0] in15_i,
  input  logic [n-1:0] in16_i,
  input  logic [n-1:0] in17_i,
  input  logic [n-1:0] in18_i,
  input  logic [n-1:0] in19_i,
  input  logic [n-1:0] in20_i,
  input  logic [n-1:0] in21_i,
  input  logic [n-1:0] in22_i,
  input  logic [n-1:0] in23_i,
  input  logic [n-1:0] in24_i,
  input  logic [n-1:0] in25_i,
  input  logic [n-1:0] in26_i,
  input  logic [n-1:0] in27_i,
  input  logic [n-1:0] in28_i,
  input  logic [n-1:0] in29_i,
  input  logic [n-1:0] in30_i,
  input  logic [n-1:0] in31_i,
  output logic [n-1:0] out_o
);

  always_comb begin
    out_o = '0;
    case (sel_i)
      5'd0:  out_o = in00_i;
      5'd1:  out_o = in01_i;
      5'd2:  out_o = in02_i;
      5'd3:  out_o = in03_i;
      5'd4:  out_o = in04_i;
      5'd5:  out_o = in05_i;
      5'd6:  out_o = in06_i;
      5'd7:  out_o = in07_i;
      5'd8:  out_o = in08_i;
      5'd9:  out_o = in09_i;
      5'd10: out_o = in10_i;
      5'd11: out_o = in11_i;
      5'd12: out_o = in12_i;
      5'd13: out_o = in13_i;
      5'd14: out_o = in14_i;
      5'd15: out_o = in15_i;
      5'd16: out_o = in16_i;
      5'd17: out_o = in17_i;
      5'd18: out_o = in18_i;
      5'd19: out_o = in19_i;
      5'd20: out_o = in20_i;
      5'd21: out_o = in21_i;
      5'd22: out_o = in22_i;
      5'd23: out_o = in23_i;
      5'd24: out_o = in24_i;
      5'd25: out_o = in25_i;
      5'd26: out_o = in26_i;
      5'd27: out_o = in27_i;
      5'd28: out_o = in28_i;
      5'd29: out_o = in29_i;
      5'd30: out_o = in30_i;
      5'd31: out_o = in31_i;
      default: out_o = '0;
    endcase
  end

endmodule

module _regfile32 #(
  parameter int n = `BIT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   rd_sel_a,
  input  logic [4:0]   rd_sel_b,
  output logic [n-1:0] rd_data_a,
  output logic [n-1:0] rd_data_b,
  output logic         busy_a,
  output logic         busy_b,
  input  logic         wr_en,
  input  logic [4:0]   wr_sel,
  input  logic [n-1:0] wr_data,
  input  logic         lock_en,
  input  logic [4:0]   lock_sel
);

  logic [n-1:0] regs_q [1:31];
  logic [n-1:0] regs_d [1:31];
  logic [31:1]  pend_q;
  logic [31:1]  pend_d;

  logic [n-1:0] storedA;
  logic [n-1:0] storedB;
  logic         pendA;
  logic         pendB;

  // Lock is applied after the write so a new producer keeps the register pending.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 1; i < 32; i++) begin
      if (wr_en && (wr_sel == 5'(i))) begin
        regs_d[i] = wr_data;
        pend_d[i] = 1'b0;
      end
      if (lock_en && (lock_sel == 5'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  _mux32 #(.n(n)) uDataMuxA (
    .sel_i(rd_sel_a),
    .in00_i('0),         .in01_i(regs_q[1]),  .in02_i(regs_q[2]),  .in03_i(regs_q[3]),
    .in04_i(regs_q[4]),  .in05_i(regs_q[5]),  .in06_i(regs_q[6]),  .in07_i(regs_q[7]),
    .in08_i(regs_q[8]),  .in09_i(regs_q[9]),  .in10_i(regs_q[10]), .in11_i(regs_q[11]),
    .in12_i(regs_q[12]), .in13_i(regs_q[13]), .in14_i(regs_q[14]), .in15_i(regs_q[15]),
    .in16_i(regs_q[16]), .in17_i(regs_q[17]), .in18_i(regs_q[18]), .in19_i(regs_q[19]),
    .in20_i(regs_q[20]), .in21_i(regs_q[21]), .in22_i(regs_q[22]), .in23_i(regs_q[23]),
    .in24_i(regs_q[24]), .in25_i(regs_q[25]), .in26_i(regs_q[26]), .in27_i(regs_q[27]),
    .in28_i(regs_q[28]), .in29_i(regs_q[29]), .in30_i(regs_q[30]), .in31_i(regs_q[31]),
    .out_o(storedA)
  );

  _mux32 #(.n(n)) uDataMuxB (
    .sel_i(rd_sel_b),
    .in00_i('0),         .in01_i(regs_q[1]),  .in02_i(regs_q[2]),  .in03_i(regs_q[3]),
    .in04_i(regs_q[4]),  .in05_i(regs_q[5]),  .in06_i(regs_q[6]),  .in07_i(regs_q[7]),
    .in08_i(regs_q[8]),  .in09_i(regs_q[9]),  .in10_i(regs_q[10]), .in11_i(regs_q[11]),
    .in12_i(regs_q[12]), .in13_i(regs_q[13]), .in14_i(regs_q[14]), .in15_i(regs_q[15]),
    .in16_i(regs_q[16]), .in17_i(regs_q[17]), .in18_i(regs_q[18]), .in19_i(regs_q[19]),
    .in20_i(regs_q[20]), .in21_i(regs_q[21]), .in22_i(regs_q[22]), .in23_i(regs_q[23]),
    .in24_i(regs_q[24]), .in25_i(regs_q[25]), .in26_i(regs_q[26]), .in27_i(regs_q[27]),
    .in28_i(regs_q[28]), .in29_i(regs_q[29]), .in30_i(regs_q[30]), .in31_i(regs_q[31]),
    .out_o(storedB)
  );

  // Pending bits go through the same one-bit-wide selection as the data.
  _mux32 #(.n(1)) uPendMuxA (
    .sel_i(rd_sel_a),
    .in00_i(1'b0),       .in01_i(pend_q[1]),  .in02_i(pend_q[2]),  .in03_i(pend_q[3]),
    .in04_i(pend_q[4]),  .in05_i(pend_q[5]),  .in06_i(pend_q[6]),  .in07_i(pend_q[7]),
    .in08_i(pend_q[8]),  .in09_i(pend_q[9]),  .in10_i(pend_q[10]), .in11_i(pend_q[11]),
    .in12_i(pend_q[12]), .in13_i(pend_q[13]), .in14_i(pend_q[14]), .in15_i(pend_q[15]),
    .in16_i(pend_q[16]), .in17_i(pend_q[17]), .in18_i(pend_q[18]), .in19_i(pend_q[19]),
    .in20_i(pend_q[20]), .in21_i(pend_q[21]), .in22_i(pend_q[22]), .in23_i(pend_q[23]),
    .in24_i(pend_q[24]), .in25_i(pend_q[25]), .in26_i(pend_q[26]), .in27_i(pend_q[27]),
    .in28_i(pend_q[28]), .in29_i(pend_q[29]), .in30_i(pend_q[30]), .in31_i(pend_q[31]),
    .out_o(pendA)
  );

  _mux32 #(.n(1)) uPendMuxB (
    .sel_i(rd_sel_b),
    .in00_i(1'b0),       .in01_i(pend_q[1]),  .in02_i(pend_q[2]),  .in03_i(pend_q[3]),
    .in04_i(pend_q[4]),  .in05_i(pend_q[5]),  .in06_i(pend_q[6]),  .in07_i(pend_q[7]),
    .in08_i(pend_q[8]),  .in09_i(pend_q[9]),  .in10_i(pend_q[10]), .in11_i(pend_q[11]),
    .in12_i(pend_q[12]), .in13_i(pend_q[13]), .in14_i(pend_q[14]), .in15_i(pend_q[15]),
    .in16_i(pend_q[16]), .in17_i(pend_q[17]), .in18_i(pend_q[18]), .in19_i(pend_q[19]),
    .in20_i(pend_q[20]), .in21_i(pend_q[21]), .in22_i(pend_q[22]), .in23_i(pend_q[23]),
    .in24_i(pend_q[24]), .in25_i(pend_q[25]), .in26_i(pend_q[26]), .in27_i(pend_q[27]),
    .in28_i(pend_q[28]), .in29_i(pend_q[29]), .in30_i(pend_q[30]), .in31_i(pend_q[31]),
    .out_o(pendB)
  );

`ifdef REGFILE_BYPASS_EN
  logic fwdA;
  logic fwdB;

  // A same-cycle write is forwarded; a same-cycle lock on that register keeps it busy.
  always_comb begin
    fwdA = wr_en && (wr_sel != 5'd0) && (wr_sel == rd_sel_a);
    fwdB = wr_en && (wr_sel != 5'd0) && (wr_sel == rd_sel_b);
    rd_data_a = fwdA ? wr_data : storedA;
    rd_data_b = fwdB ? wr_data : storedB;
    busy_a = fwdA ? (lock_en && (lock_sel == rd_sel_a)) : pendA;
    busy_b = fwdB ? (lock_en && (lock_sel == rd_sel_b)) : pendB;
  end
`else
  always_comb begin
    rd_data_a = storedA;
    rd_data_b = storedB;
    busy_a = pendA;
    busy_b = pendB;
  end
`endif

endmodule

// File: tb/tb__regfile32.sv
// Directed self-checking bench for _regfile32; expectations are hand-computed
// and follow REGFILE_BYPASS_EN when the bench is built with it.
`timescale 1ns/1ps

module tb__regfile32;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_sel_a;
  logic [4:0]  rd_sel_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [31:0] wr_data;
  logic        lock_en;
  logic [4:0]  lock_sel;

  int vectors = 0;
  int miscompares = 0;

  _regfile32 #(.n(32)) dut (
    .clk(clk), .rst(rst),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .lock_en(lock_en), .lock_sel(lock_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle's write/lock request and leaves the read selects alone.
  task automatic applyStimulus(input logic we, input logic [4:0] ws, input logic [31:0] wd,
                               input logic le, input logic [4:0] ls);
    wr_en = we;
    wr_sel = ws;
    wr_data = wd;
    lock_en = le;
    lock_sel = ls;
  endtask

  // Waits one rising edge and settles just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_sel_a = '0;
    rd_sel_b = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    rst = 1'b0;

    // Reset state over every index.
    for (int k = 0; k < 32; k++) begin
      rd_sel_a = 5'(k);
      rd_sel_b = 5'(31 - k);
      #1;
      checkOutput($sformatf("rst_data_a[%0d]", k), rd_data_a, 32'h0);
      checkOutput($sformatf("rst_busy_a[%0d]", k), {31'h0, busy_a}, 32'h0);
      checkOutput($sformatf("rst_data_b[%0d]", 31 - k), rd_data_b, 32'h0);
    end

    // Register 0 ignores writes and locks.
    applyStimulus(1'b1, 5'd0, 32'hA5, 1'b1, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd_sel_a = 5'd0;
    #1;
    checkOutput("r0_data", rd_data_a, 32'h0);
    checkOutput("r0_busy", {31'h0, busy_a}, 32'h0);

    // Fill index k with 3k, then read both ports.
    for (int k = 1; k < 32; k++) begin
      applyStimulus(1'b1, 5'(k), 32'(3 * k), 1'b0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    for (int k = 0; k < 32; k++) begin
      rd_sel_a = 5'(k);
      rd_sel_b = 5'(31 - k);
      #1;
      checkOutput($sformatf("fill_a[%0d]", k), rd_data_a, 32'(3 * k));
      checkOutput($sformatf("fill_b[%0d]", 31 - k), rd_data_b, 32'(3 * (31 - k)));
      checkOutput($sformatf("fill_busy_a[%0d]", k), {31'h0, busy_a}, 32'h0);
    end

    // Lock index 5, lock it again, then one write clears it.
    rd_sel_a = 5'd5;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    tick();
    checkOutput("lock5_busy", {31'h0, busy_a}, 32'h1);
    checkOutput("lock5_data", rd_data_a, 32'd15);
    tick();
    checkOutput("relock5_busy", {31'h0, busy_a}, 32'h1);
    applyStimulus(1'b1, 5'd5, 32'h3C, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("wr5_busy", {31'h0, busy_a}, 32'h0);
    checkOutput("wr5_data", rd_data_a, 32'h3C);

    // Lock and write on the same index: lock wins.
    rd_sel_b = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd7);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("lw7_data", rd_data_b, 32'h77);
    checkOutput("lw7_busy", {31'h0, busy_b}, 32'h1);

    // Lock and write on different indices.
    rd_sel_a = 5'd8;
    rd_sel_b = 5'd10;
    applyStimulus(1'b1, 5'd10, 32'hABCD, 1'b1, 5'd8);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("split_busy8", {31'h0, busy_a}, 32'h1);
    checkOutput("split_data8", rd_data_a, 32'd24);
    checkOutput("split_data10", rd_data_b, 32'hABCD);
    checkOutput("split_busy10", {31'h0, busy_b}, 32'h0);

    // Same-cycle read of a write to index 9 (holds 27).
    rd_sel_a = 5'd9;
    applyStimulus(1'b1, 5'd9, 32'h55, 1'b0, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp9_same", rd_data_a, 32'h55);
`else
    checkOutput("byp9_same", rd_data_a, 32'd27);
`endif
    checkOutput("byp9_busy", {31'h0, busy_a}, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("byp9_next", rd_data_a, 32'h55);

    // Same-cycle write plus lock on index 11 (holds 33), read on port B.
    rd_sel_b = 5'd11;
    applyStimulus(1'b1, 5'd11, 32'h66, 1'b1, 5'd11);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp11_same", rd_data_b, 32'h66);
    checkOutput("byp11_busy", {31'h0, busy_b}, 32'h1);
`else
    checkOutput("byp11_same", rd_data_b, 32'd33);
    checkOutput("byp11_busy", {31'h0, busy_b}, 32'h0);
`endif
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("byp11_next", rd_data_b, 32'h66);
    checkOutput("byp11_nbusy", {31'h0, busy_b}, 32'h1);

    // Reset beats a simultaneous write and lock.
    rd_sel_a = 5'd4;
    rd_sel_b = 5'd6;
    applyStimulus(1'b1, 5'd4, 32'h11, 1'b1, 5'd4);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("pre_rst_data4", rd_data_a, 32'h11);
    checkOutput("pre_rst_busy4", {31'h0, busy_a}, 32'h1);
    rst = 1'b1;
    applyStimulus(1'b1, 5'd4, 32'h22, 1'b1, 5'd6);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("rstp_data4", rd_data_a, 32'h0);
    checkOutput("rstp_busy6", {31'h0, busy_b}, 32'h0);
    for (int k = 0; k < 32; k++) begin
      rd_sel_a = 5'(k);
      #1;
      checkOutput($sformatf("rstp_busy[%0d]", k), {31'h0, busy_a}, 32'h0);
      checkOutput($sformatf("rstp_data[%0d]", k), rd_data_a, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/_regfile32.md
# _regfile32

Thirty-two-entry, n-bit general-purpose register file that feeds the CPU's operand-select stage. It has two combinational read ports, each built from a `_mux32` instance, and one synchronous write port. A per-register pending (scoreboard) bit lets the issue stage stall on registers whose producer has not yet written back. Register 0 is hardwired to zero.

## Interface
- `n`, default `BIT_WIDTH`: width of each register and of all data ports.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high; sampled on the `clk` rising edge.
- `rd_sel_a` input 5: read port A register index.
- `rd_sel_b` input 5: read port B register index.
- `rd_data_a` output n: contents of register `rd_sel_a`.
- `rd_data_b` output n: contents of register `rd_sel_b`.
- `busy_a` output 1: pending bit of register `rd_sel_a`.
- `busy_b` output 1: pending bit of register `rd_sel_b`.
- `wr_en` input 1: write strobe.
- `wr_sel` input 5: write register index.
- `wr_data` input n: write data.
- `lock_en` input 1: mark a register pending (producer issued).
- `lock_sel` input 5: register index to mark.

## Operation
- Storage is `regs[1..31]`, each n bits, plus `pend[1..31]`. Index 0 has no storage:
  - reads of 0 return 0 and `busy` 0;
  - writes and locks to 0 are ignored.
- Reads: `regs` is fed into two `_mux32` instances. Sel = `rd_sel_a`/`rd_sel_b` and in00 = zero. `busy_x` comes from the same selection applied to the `pend` vector.
- Write: when `wr_en` is high and `wr_sel` is nonzero, `regs[wr_sel] <= wr_data` and `pend[wr_sel] <= 0`.
- Lock: when `lock_en` is high and `lock_sel` is nonzero, `pend[lock_sel] <= 1`.
- Lock and write to the same register in the same cycle:
  - data is written;
  - `pend` ends at 1, because lock wins (a new producer supersedes the completing one).
- Lock and write to different registers in the same cycle: both take effect independently.
- Repeated lock on an already-pending register: no change; there is no count.
- Reset: all `regs` go to 0 and all `pend` go to 0. Reset overrides `wr_en` and `lock_en` in the same cycle.
- The block does not stall or refuse writes; the issue stage uses `busy_x` itself.

## Timing
- Read latency is 0 cycles. Outputs are combinational from `rd_sel_x` and the current state.
- Write and lock become visible on the cycle after the edge that samples them. With the bypass macro enabled, a write is also visible in the same cycle (see Configuration).
- Output values after reset:
  - `rd_data_a = rd_data_b = 0` for any select;
  - `busy_a = busy_b = 0`.
- Reset asserted mid-sequence: state is cleared on that edge. Any write or lock presented on that edge is lost.
- No handshake and no back-pressure. Every write presented is accepted on its edge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- When defined, write-to-read forwarding applies. If `wr_en` is high, `wr_sel` is nonzero and equals `rd_sel_x`:
  - `rd_data_x = wr_data` in the same cycle;
  - `busy_x = 0` in that cycle, unless `lock_en` is high with `lock_sel == rd_sel_x`, in which case `busy_x = 1`.
- When undefined, reads return only stored state. The same-cycle read returns the old value and the old pending bit; the new value appears on the next cycle.
- The macro has no effect on stored state or on reset behaviour.

## Test plan
- Reset state: assert `rst` for 1 cycle, then sweep `rd_sel_a` over 0..31 -> `rd_data_a == 0` and `busy_a == 0` for every index.
- Register 0 is immutable: write 0xA5 to index 0 with `lock_en` on index 0 -> next cycle, reading index 0 gives 0 and busy 0.
- Write/read on both ports: write index k with value k*3 for k = 1..31, then read A = k and B = 31-k -> `rd_data_a == 3k`, `rd_data_b == 3(31-k)`. Index 0 reads 0.
- Scoreboard:
  - lock index 5 -> `busy_a` (sel 5) is 1 the next cycle;
  - write index 5 with 0x3C -> next cycle, busy is 0 and data is 0x3C;
  - simultaneous lock and write on index 7 -> data updated and busy stays 1.
- Bypass: write 0x55 to index 9 while `rd_sel_a = 9` in the same cycle.
  - With `REGFILE_BYPASS_EN`: `rd_data_a == 0x55` in that cycle.
  - Without it: the old value that cycle and 0x55 the next.
- Reset priority: with index 4 holding 0x11 and pending, assert `rst` together with `wr_en` (index 4, 0x22) and `lock_en` (index 6) -> next cycle, index 4 reads 0, index 6 is not busy, and all busy bits are 0.
